// File: rtl/xadc_packet_package.sv
// Shared XADC packet definitions: header codes, field widths and packetizer types.
package xadc_packet_package;

   localparam int XADC_PACKET_HEADER_WIDTH = 4;
   localparam int XADC_PACKET_FIELD_WIDTH  = 12;
   localparam int XADC_PACKET_BYTES        = 4;

   typedef enum logic [XADC_PACKET_HEADER_WIDTH-1:0] {
      XADC_PACKET_HEADER_LOW_SPEED_SAMPLE = 4'h1,
      XADC_PACKET_HEADER_HIGHSPEED_SAMPLE = 4'h3
   } xadc_packet_header_t;

   typedef enum logic {
      XADC_PKT_IDLE,
      XADC_PKT_SEND
   } xadc_packetizer_state_t;

   typedef enum logic {
      XADC_SRC_LS,
      XADC_SRC_HS
   } xadc_sample_source_t;

   // Word layout {hdr, A, 4'h0, B}; byte 0 on the wire is bits [31:24].
   function automatic logic [31:0] xadc_build_packet(
      input xadc_packet_header_t                hdr,
      input logic [XADC_PACKET_FIELD_WIDTH-1:0] field_a,
      input logic [XADC_PACKET_FIELD_WIDTH-1:0] field_b
   );
      return {hdr, field_a, 4'h0, field_b};
   endfunction

endpackage

// File: rtl/xadc_sample_slot.sv
// One-deep holding slot for a non-stallable sample pair; newest sample always wins.
module xadc_sample_slot #(
   parameter int SAMPLE_WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    strobe,
   input  logic                    take,
   input  logic [SAMPLE_WIDTH-1:0] sample_a,
   input  logic [SAMPLE_WIDTH-1:0] sample_b,
   output logic                    pending,
   output logic [SAMPLE_WIDTH-1:0] held_a,
   output logic [SAMPLE_WIDTH-1:0] held_b,
   output logic                    overflow
);

   // A strobe landing on the cycle the slot is taken refills it; nothing is lost.
   assign overflow = strobe && pending && !take;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending <= 1'b0;
         held_a  <= '0;
         held_b  <= '0;
      end else if (strobe) begin
         pending <= 1'b1;
         held_a  <= sample_a;
         held_b  <= sample_b;
      end else if (take) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/xadc_sample_packetizer.sv
// Serialises LS/HS XADC sample pairs into 4-byte headered packets on a byte stream.
// Optional XADC_PACKETIZER_OVERFLOW_COUNT_EN adds saturating per-source overwrite counters.
module xadc_sample_packetizer
   import xadc_packet_package::*;
#(
   parameter int SAMPLE_WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    ls_valid,
   input  logic [SAMPLE_WIDTH-1:0] ls_voltage,
   input  logic [SAMPLE_WIDTH-1:0] ls_current,
   input  logic                    hs_valid,
   input  logic [SAMPLE_WIDTH-1:0] hs_ch0,
   input  logic [SAMPLE_WIDTH-1:0] hs_ch1,
   output logic [7:0]              m_tdata,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic                    m_tlast,
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
   output logic [15:0]             ls_overflow_count,
   output logic [15:0]             hs_overflow_count,
`endif
   output xadc_packetizer_state_t  dbg_state
);

   localparam logic [1:0] LAST_IDX = 2'(XADC_PACKET_BYTES - 1);

   xadc_packetizer_state_t  state;
   xadc_sample_source_t     last_src;
   logic [31:0]             shift_reg;
   logic [1:0]              byte_idx;
   logic                    ls_pending, hs_pending, ls_take, hs_take, ls_ovf, hs_ovf;
   logic [SAMPLE_WIDTH-1:0] ls_a, ls_b, hs_a, hs_b;
   logic [31:0]             ls_pkt, hs_pkt;

   xadc_sample_slot #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_ls_slot (
      .clk(clk), .reset_n(reset_n), .strobe(ls_valid), .take(ls_take),
      .sample_a(ls_voltage), .sample_b(ls_current),
      .pending(ls_pending), .held_a(ls_a), .held_b(ls_b), .overflow(ls_ovf)
   );

   xadc_sample_slot #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_hs_slot (
      .clk(clk), .reset_n(reset_n), .strobe(hs_valid), .take(hs_take),
      .sample_a(hs_ch0), .sample_b(hs_ch1),
      .pending(hs_pending), .held_a(hs_a), .held_b(hs_b), .overflow(hs_ovf)
   );

   assign ls_pkt = xadc_build_packet(XADC_PACKET_HEADER_LOW_SPEED_SAMPLE,
                                     XADC_PACKET_FIELD_WIDTH'(ls_a), XADC_PACKET_FIELD_WIDTH'(ls_b));
   assign hs_pkt = xadc_build_packet(XADC_PACKET_HEADER_HIGHSPEED_SAMPLE,
                                     XADC_PACKET_FIELD_WIDTH'(hs_a), XADC_PACKET_FIELD_WIDTH'(hs_b));

   // On a tie the source not sent last goes next, so neither can starve the other.
   always_comb begin
      ls_take = 1'b0;
      hs_take = 1'b0;
      if (state == XADC_PKT_IDLE) begin
         if (ls_pending && (!hs_pending || last_src == XADC_SRC_HS)) ls_take = 1'b1;
         else if (hs_pending)                                        hs_take = 1'b1;
      end
   end

   // Byte stream: a byte moves when m_tvalid && m_tready at a clock edge; while
   // m_tvalid is high and m_tready low, m_tdata/m_tlast/m_tvalid hold steady.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= XADC_PKT_IDLE;
         last_src  <= XADC_SRC_HS;
         shift_reg <= '0;
         byte_idx  <= '0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_tdata   <= '0;
      end else begin
         case (state)
            XADC_PKT_IDLE: begin
               if (ls_take || hs_take) begin
                  shift_reg <= ls_take ? ls_pkt : hs_pkt;
                  m_tdata   <= ls_take ? ls_pkt[31:24] : hs_pkt[31:24];
                  last_src  <= ls_take ? XADC_SRC_LS : XADC_SRC_HS;
                  byte_idx  <= '0;
                  m_tvalid  <= 1'b1;
                  m_tlast   <= 1'b0;
                  state     <= XADC_PKT_SEND;
               end
            end
            XADC_PKT_SEND: begin
               if (m_tvalid && m_tready) begin
                  if (byte_idx == LAST_IDX) begin
                     byte_idx <= '0;
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     state    <= XADC_PKT_IDLE;
                  end else begin
                     shift_reg <= {shift_reg[23:0], 8'h00};
                     m_tdata   <= shift_reg[23:16];
                     m_tlast   <= (byte_idx == LAST_IDX - 2'd1);
                     byte_idx  <= byte_idx + 2'd1;
                  end
               end
            end
            default: state <= XADC_PKT_IDLE;
         endcase
      end
   end

   assign dbg_state = state;

`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ls_overflow_count <= '0;
         hs_overflow_count <= '0;
      end else begin
         if (ls_ovf && ls_overflow_count != 16'hFFFF) ls_overflow_count <= ls_overflow_count + 16'd1;
         if (hs_ovf && hs_overflow_count != 16'hFFFF) hs_overflow_count <= hs_overflow_count + 16'd1;
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = ls_ovf ^ hs_ovf;
`endif

endmodule

// File: tb/tb_xadc_sample_packetizer.sv
// Directed self-checking bench for xadc_sample_packetizer (either XADC_PACKETIZER_OVERFLOW_COUNT_EN build).
module tb_xadc_sample_packetizer;
   import xadc_packet_package::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ls_valid = 1'b0, hs_valid = 1'b0;
   logic [11:0] ls_voltage = '0, ls_current = '0, hs_ch0 = '0, hs_ch1 = '0;
   logic        m_tready = 1'b0;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tlast;
   xadc_packetizer_state_t dbg_state;
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
   logic [15:0] ls_overflow_count, hs_overflow_count;
   logic [15:0] exp_ls_ovf = '0, exp_hs_ovf = '0;
`endif

   logic [8:0] exp_q[$];
   logic [8:0] got_q[$];
   int total = 0;
   int bad = 0;

   xadc_sample_packetizer #(.SAMPLE_WIDTH(12)) dut (
      .clk(clk), .reset_n(reset_n),
      .ls_valid(ls_valid), .ls_voltage(ls_voltage), .ls_current(ls_current),
      .hs_valid(hs_valid), .hs_ch0(hs_ch0), .hs_ch1(hs_ch1),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      .ls_overflow_count(ls_overflow_count), .hs_overflow_count(hs_overflow_count),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   // monitor: a byte is accepted when tvalid && tready are high ahead of an edge
   always @(negedge clk) begin
      if (reset_n && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
   end

   // driver tasks (inputs change 1 time unit after the rising edge)
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_ls(input logic [11:0] v, input logic [11:0] i);
      ls_valid = 1'b1; ls_voltage = v; ls_current = i;
      step(1);
      ls_valid = 1'b0;
   endtask

   task automatic pulse_hs(input logic [11:0] c0, input logic [11:0] c1);
      hs_valid = 1'b1; hs_ch0 = c0; hs_ch1 = c1;
      step(1);
      hs_valid = 1'b0;
   endtask

   task automatic pulse_both(input logic [11:0] v, input logic [11:0] i,
                             input logic [11:0] c0, input logic [11:0] c1);
      ls_valid = 1'b1; ls_voltage = v; ls_current = i;
      hs_valid = 1'b1; hs_ch0 = c0; hs_ch1 = c1;
      step(1);
      ls_valid = 1'b0;
      hs_valid = 1'b0;
   endtask

   task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      exp_q.push_back({1'b0, b0});
      exp_q.push_back({1'b0, b1});
      exp_q.push_back({1'b0, b2});
      exp_q.push_back({1'b1, b3});
   endtask

   task automatic wait_bytes(input int n, output bit ok);
      int c = 0;
      while (got_q.size() < n && c < 200) begin
         step(1);
         c++;
      end
      ok = (got_q.size() >= n);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step(3);
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00) begin
         bad++;
         $display("FAIL reset_outputs got tvalid=%b tlast=%b tdata=%h exp 0 0 00", m_tvalid, m_tlast, m_tdata);
      end
      total++;
      if (dbg_state !== XADC_PKT_IDLE) begin
         bad++;
         $display("FAIL reset_state got=%0d exp=%0d", dbg_state, XADC_PKT_IDLE);
      end
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      total++;
      if (ls_overflow_count !== 16'd0 || hs_overflow_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_counters got ls=%0d hs=%0d exp 0 0", ls_overflow_count, hs_overflow_count);
      end
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(2);
   endtask

   task automatic test_ls_packet();
      bit ok;
      logic [8:0] g, e;
      exp_q.delete(); got_q.delete();
      m_tready = 1'b1;
      push_bytes(8'h1A, 8'hBC, 8'h01, 8'h23);
      pulse_ls(12'hABC, 12'h123);
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL ls_latency_n1 got tvalid=%b exp 0", m_tvalid);
      end
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h1A) begin
         bad++;
         $display("FAIL ls_latency_n2 got tvalid=%b tdata=%h exp 1 1a", m_tvalid, m_tdata);
      end
      wait_bytes(4, ok);
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b0) begin
         bad++;
         $display("FAIL ls_idle_gap got tvalid=%b exp 0", m_tvalid);
      end
      step(6);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL ls_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL ls_byte got last/data=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_stall_hold();
      bit ok;
      logic [8:0] g, e;
      exp_q.delete(); got_q.delete();
      m_tready = 1'b0;
      push_bytes(8'h30, 8'hFF, 8'h0F, 8'h00);
      pulse_hs(12'h0FF, 12'hF00);
      @(negedge clk);
      @(negedge clk);
      repeat (5) begin
         total++;
         if (m_tvalid !== 1'b1 || m_tdata !== 8'h30 || m_tlast !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold got tvalid=%b tdata=%h tlast=%b exp 1 30 0", m_tvalid, m_tdata, m_tlast);
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      wait_bytes(4, ok);
      step(6);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL stall_byte got last/data=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_arbitration();
      bit ok;
      logic [8:0] g, e;
      exp_q.delete(); got_q.delete();
      m_tready = 1'b1;
      // tie -> LS; refill both during the LS packet -> HS (overwritten) then LS
      push_bytes(8'h13, 8'h21, 8'h06, 8'h54);
      push_bytes(8'h3A, 8'h5A, 8'h05, 8'hA5);
      push_bytes(8'h10, 8'hF0, 8'h00, 8'h0F);
      pulse_both(12'h321, 12'h654, 12'h111, 12'h222);
      step(1);
      pulse_both(12'h0F0, 12'h00F, 12'hA5A, 12'h5A5);
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      exp_hs_ovf = exp_hs_ovf + 16'd1;
`endif
      wait_bytes(12, ok);
      step(8);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL arb_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL arb_byte got last/data=%h exp=%h", g, e);
         end
      end
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      total++;
      if (ls_overflow_count !== exp_ls_ovf || hs_overflow_count !== exp_hs_ovf) begin
         bad++;
         $display("FAIL arb_ovf got ls=%0d hs=%0d exp ls=%0d hs=%0d", ls_overflow_count, hs_overflow_count, exp_ls_ovf, exp_hs_ovf);
      end
`endif
   endtask

   task automatic test_overflow();
      bit ok;
      logic [8:0] g, e;
      exp_q.delete(); got_q.delete();
      m_tready = 1'b0;
      push_bytes(8'h15, 8'h55, 8'h0A, 8'hAA);
      push_bytes(8'h37, 8'h89, 8'h0D, 8'hEF);
      pulse_ls(12'h555, 12'hAAA);
      step(1);
      pulse_hs(12'h111, 12'h222);
      pulse_hs(12'h333, 12'h444);
      pulse_hs(12'h789, 12'hDEF);
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      exp_hs_ovf = exp_hs_ovf + 16'd2;
`endif
      step(2);
      m_tready = 1'b1;
      wait_bytes(8, ok);
      step(8);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL ovf_byte got last/data=%h exp=%h", g, e);
         end
      end
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      total++;
      if (ls_overflow_count !== exp_ls_ovf || hs_overflow_count !== exp_hs_ovf) begin
         bad++;
         $display("FAIL ovf_counter got ls=%0d hs=%0d exp ls=%0d hs=%0d", ls_overflow_count, hs_overflow_count, exp_ls_ovf, exp_hs_ovf);
      end
`endif
   endtask

   task automatic test_load_collision();
      bit ok;
      logic [8:0] g, e;
      exp_q.delete(); got_q.delete();
      m_tready = 1'b1;
      // second strobe lands on the edge where the FSM loads the HS slot
      push_bytes(8'h30, 8'hAB, 8'h0C, 8'hD0);
      push_bytes(8'h34, 8'h56, 8'h07, 8'h89);
      pulse_hs(12'h0AB, 12'hCD0);
      pulse_hs(12'h456, 12'h789);
      wait_bytes(8, ok);
      step(8);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL coll_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL coll_byte got last/data=%h exp=%h", g, e);
         end
      end
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      total++;
      if (ls_overflow_count !== exp_ls_ovf || hs_overflow_count !== exp_hs_ovf) begin
         bad++;
         $display("FAIL coll_counter got ls=%0d hs=%0d exp ls=%0d hs=%0d", ls_overflow_count, hs_overflow_count, exp_ls_ovf, exp_hs_ovf);
      end
`endif
   endtask

   task automatic test_reset_mid_packet();
      bit ok;
      logic [8:0] g, e;
      exp_q.delete(); got_q.delete();
      m_tready = 1'b1;
      exp_q.push_back({1'b0, 8'h12});
      exp_q.push_back({1'b0, 8'h46});
      pulse_both(12'h246, 12'h135, 12'h777, 12'h888);
      wait_bytes(2, ok);
      reset_n = 1'b0;
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'h01) begin
         bad++;
         $display("FAIL rst_byte2 got tvalid=%b tdata=%h exp 1 01", m_tvalid, m_tdata);
      end
      @(negedge clk);
      total++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || dbg_state !== XADC_PKT_IDLE) begin
         bad++;
         $display("FAIL rst_abort got tvalid=%b tlast=%b state=%0d exp 0 0 0", m_tvalid, m_tlast, dbg_state);
      end
`ifdef XADC_PACKETIZER_OVERFLOW_COUNT_EN
      exp_ls_ovf = '0;
      exp_hs_ovf = '0;
      total++;
      if (ls_overflow_count !== exp_ls_ovf || hs_overflow_count !== exp_hs_ovf) begin
         bad++;
         $display("FAIL rst_counter got ls=%0d hs=%0d exp 0 0", ls_overflow_count, hs_overflow_count);
      end
`endif
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(10);
      // the pending HS sample must have been dropped by the reset
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rst_drop_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL rst_partial_byte got last/data=%h exp=%h", g, e);
         end
      end
      exp_q.delete(); got_q.delete();
      push_bytes(8'h39, 8'hAB, 8'h0C, 8'hDE);
      pulse_hs(12'h9AB, 12'hCDE);
      wait_bytes(4, ok);
      step(8);
      total++;
      if (!ok || got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL rst_fresh_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front(); e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL rst_fresh_byte got last/data=%h exp=%h", g, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ls_packet();
      test_stall_hold();
      test_arbitration();
      test_overflow();
      test_load_collision();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
